// File: rtl/usb_key_birthday_2000_10_29_pkg.sv
// Shared definitions for the birthday-message key: controller states and the
// fixed ASCII message "2000_10_29".
package usb_key_birthday_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_NEXT = 2'd2
    } ctrl_state_t;

    localparam int MSG_LEN = 10;

    // Packed so that element 0 is the first byte on the wire.
    localparam logic [MSG_LEN-1:0][7:0] MSG_BYTES = {
        8'h39, 8'h32, 8'h5F, 8'h30, 8'h31,
        8'h5F, 8'h30, 8'h30, 8'h30, 8'h32
    };

    function automatic logic [7:0] msg_byte(input logic [3:0] idx);
        if (idx < 4'(MSG_LEN)) begin
            return MSG_BYTES[idx];
        end
        return 8'hFF;
    endfunction

endpackage

// File: rtl/usb_key_birthday_2000_10_29_uart_tx.sv
// 8N1 UART transmitter, LSB first. 'done' pulses one clock before the stop bit
// ends so the caller can queue the next byte with no idle gap between frames.
module uart_tx #(
    parameter int BIT_CYCLES = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BIT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [BIT_W-1:0] baud_cnt_reg;
    logic [3:0]       bit_idx_reg;
    logic [8:0]       shift_reg;
    logic             tx_reg;
    logic             busy_reg;

    logic bit_end;
    logic frame_last;
    logic accept;

    assign bit_end    = busy_reg && (baud_cnt_reg == BIT_W'(BIT_CYCLES - 1));
    assign frame_last = bit_end && (bit_idx_reg == 4'd9);
    assign done       = busy_reg && (bit_idx_reg == 4'd9) &&
                        (baud_cnt_reg == BIT_W'(BIT_CYCLES - 2));
    // A new frame may begin on the very clock the previous stop bit finishes.
    assign accept     = start && (!busy_reg || frame_last);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '1;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else if (accept) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= {1'b1, data};
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
        end else if (frame_last) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else if (bit_end) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= bit_idx_reg + 4'd1;
            tx_reg       <= shift_reg[0];
            shift_reg    <= {1'b1, shift_reg[8:1]};
        end else if (busy_reg) begin
            baud_cnt_reg <= baud_cnt_reg + BIT_W'(1);
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: rtl/usb_key_birthday_2000_10_29.sv
// Push-button to UART: each debounced press sends "2000_10_29" once.
// Holds the key synchronizer, the debouncer and the message sequencer.
module usb_key_birthday_2000_10_29
    import usb_key_birthday_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic tx
);

    localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
    localparam int DEB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             key_meta_reg;
    logic             key_sync_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             held_reg;
    logic             press_reg;
    ctrl_state_t      state_reg;
    logic [3:0]       idx_reg;

    logic       uart_start;
    logic [7:0] uart_data;
    logic       uart_busy;
    logic       uart_done;
    logic       deb_full;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            key_meta_reg <= 1'b1;
            key_sync_reg <= 1'b1;
        end else begin
            key_meta_reg <= key;
            key_sync_reg <= key_meta_reg;
        end
    end

    assign deb_full = (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1));

    // held_reg remembers that this low period already fired, so a long hold
    // at the saturated count yields only one pulse.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            deb_cnt_reg <= '0;
            held_reg    <= 1'b0;
            press_reg   <= 1'b0;
        end else if (key_sync_reg) begin
            deb_cnt_reg <= '0;
            held_reg    <= 1'b0;
            press_reg   <= 1'b0;
        end else begin
            if (!deb_full) begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
            press_reg <= deb_full && !held_reg;
            if (deb_full) begin
                held_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    idx_reg <= '0;
                    if (press_reg) begin
                        state_reg <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uart_done) begin
                        if (idx_reg == 4'(MSG_LEN - 1)) begin
                            state_reg <= ST_IDLE;
                            idx_reg   <= '0;
                        end else begin
                            state_reg <= ST_NEXT;
                            idx_reg   <= idx_reg + 4'd1;
                        end
                    end else if (!uart_busy) begin
                        state_reg <= ST_IDLE;
                        idx_reg   <= '0;
                    end
                end
                ST_NEXT: begin
                    state_reg <= ST_SEND;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    // NEXT coincides with the final stop-bit clock, so the next byte is
    // accepted exactly as the previous frame ends.
    assign uart_start = ((state_reg == ST_IDLE) && press_reg) || (state_reg == ST_NEXT);
    assign uart_data  = msg_byte(idx_reg);

    uart_tx #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_uart_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(uart_start),
        .data (uart_data),
        .tx   (tx),
        .busy (uart_busy),
        .done (uart_done)
    );

endmodule

// File: tb/tb_usb_key_birthday_2000_10_29.sv
// Bench for the birthday-message key, run with short timing parameters
// (8 clocks per bit, 64-clock debounce) and a decoding UART monitor.
module tb_usb_key_birthday_2000_10_29;

    localparam int BIT     = 8;
    localparam int DEB     = 64;
    localparam int NBYTES  = 10;
    localparam int MSG_CYC = NBYTES * 10 * BIT;

    logic clk = 1'b0;
    logic rst_n;
    logic key;
    logic tx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_frames = 0;
    int press_cyc = 0;
    int last_start = 0;

    typedef struct {
        logic [7:0] b;
        bit         first;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] msg_exp [NBYTES] = '{8'h32, 8'h30, 8'h30, 8'h30, 8'h5F,
                                     8'h31, 8'h30, 8'h5F, 8'h32, 8'h39};

    usb_key_birthday_2000_10_29 #(
        .CLK_FREQ_HZ    (80),
        .BAUD_RATE      (10),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .tx   (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_msg();
        for (int i = 0; i < NBYTES; i++) begin
            exp_q.push_back('{msg_exp[i], (i == 0)});
        end
    endtask

    task automatic press_hold(input int low_cycles, input bit expect_msg);
        @(negedge clk);
        key = 1'b0;
        press_cyc = cyc;
        if (expect_msg) push_msg();
        repeat (low_cycles) @(negedge clk);
        key = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (n_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("frames_reached", n_frames, target);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int base = n_frames;
        repeat (cycles) @(negedge clk);
        check(tag, n_frames, base);
    endtask

    // UART monitor: decodes every frame, checks framing, bit width, spacing
    // and start latency, and compares each byte against the scoreboard.
    initial begin
        logic [9:0] bitval;
        bit width_ok, aborted;
        int frame_start, lat;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n && tx === 1'b0) begin
                frame_start = cyc;
                width_ok = 1'b1;
                aborted = 1'b0;
                bitval = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < BIT; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (rst_n) aborted = 1'b1;
                        if (c == 0) bitval[b] = tx;
                        else if (tx !== bitval[b]) width_ok = 1'b0;
                    end
                end
                if (aborted) begin
                    $display("frame at cycle %0d cut short by reset", frame_start);
                end else begin
                    check("start_bit", 32'(bitval[0]), 32'd0);
                    check("stop_bit", 32'(bitval[9]), 32'd1);
                    check("bit_width", 32'(width_ok), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(bitval[8:1]), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(bitval[8:1]), 32'(e.b));
                        if (e.first) begin
                            lat = frame_start - press_cyc;
                            check("start_latency", 32'(lat >= DEB + 2 && lat <= DEB + 4), 32'd1);
                        end else begin
                            check("back_to_back", 32'(frame_start - last_start), 32'(10 * BIT));
                        end
                        $display("frame %0d at cycle %0d: 0x%02h (expected 0x%02h)",
                                 n_frames, frame_start, bitval[8:1], e.b);
                    end
                    last_start = frame_start;
                    n_frames++;
                end
            end
        end
    end

    initial begin
        int base;
        key = 1'b1;
        rst_n = 1'b1;
        #7;
        check("tx_in_reset", 32'(tx), 32'd1);
        #7;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("tx_idle_after_reset", 32'(tx), 32'd1);

        // Valid long press
        press_hold(DEB + 20, 1'b1);
        wait_frames(10, MSG_CYC + 3 * DEB);
        check("queue_empty_1", 32'(exp_q.size()), 32'd0);

        // Low one clock short of the debounce time: nothing sent
        press_hold(DEB - 1, 1'b0);
        idle_check("short_press_ignored", 3 * DEB);
        check("tx_high_after_short", 32'(tx), 32'd1);

        // Low for exactly the debounce time: message sent
        press_hold(DEB, 1'b1);
        wait_frames(20, MSG_CYC + 3 * DEB);

        // Bouncing, then a stable press
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) key = 1'b0;
            repeat (DEB / 4) @(negedge clk);
            key = 1'b1;
            repeat (DEB / 4) @(negedge clk);
        end
        press_hold(DEB + 20, 1'b1);
        wait_frames(30, MSG_CYC + 3 * DEB);

        // Second valid press during transmission is ignored
        press_hold(DEB + 5, 1'b1);
        repeat (100) @(negedge clk);
        press_hold(DEB + 5, 1'b0);
        wait_frames(40, MSG_CYC + 3 * DEB);
        idle_check("press_during_tx_ignored", 3 * DEB);
        press_hold(DEB + 5, 1'b1);
        wait_frames(50, MSG_CYC + 3 * DEB);

        // Reset during the fifth byte aborts the message
        base = n_frames;
        press_hold(DEB + 5, 1'b1);
        wait_frames(base + 4, MSG_CYC + 3 * DEB);
        repeat (3 * BIT) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("tx_on_reset_assert", 32'(tx), 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        check("bytes_dropped_by_reset", 32'(exp_q.size()), 32'd6);
        exp_q.delete();
        idle_check("silent_after_reset", 3 * DEB + MSG_CYC);
        check("tx_high_after_reset", 32'(tx), 32'd1);

        // Key held low across reset release needs a full debounce afterwards
        @(negedge clk) key = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        press_cyc = cyc;
        push_msg();
        repeat (DEB + 10) @(negedge clk);
        key = 1'b1;
        wait_frames(base + 14, MSG_CYC + 3 * DEB);
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_key_birthday_2000_10_29.md
USB_KEY_BIRTHDAY_2000_10_29 -- requirements
Module: usb_key_birthday_2000_10_29

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency.
REQ-002 Parameter BAUD_RATE, default 115_200, UART bit rate; BIT_CYCLES = CLK_FREQ_HZ/BAUD_RATE (integer divide; 434 at defaults).
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000, key stable-low time (20 ms at 50 MHz).
REQ-004 Port clk, input, 1, single system clock; all logic on rising edge.
REQ-005 Port rst_n, input, 1, reset, asynchronous, active-high (asserted = 1 despite the _n suffix).
REQ-006 Port key, input, 1, asynchronous push-button, idle high, pressed low.
REQ-007 Port tx, output, 1, UART serial output, 8N1, LSB first, idle high.

Function
REQ-008 key SHALL pass through a 2-flop synchronizer before any use.
REQ-009 Debounce counter SHALL increment each cycle the synchronized key is low and clear to 0 on any cycle it is high.
REQ-010 A single-cycle press pulse SHALL fire when the counter reaches DEBOUNCE_CYCLES-1; counter SHALL saturate there, so one held press yields exactly one pulse.
REQ-011 Low pulses shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-012 Press pulse SHALL start transmission of the fixed 10-byte ASCII message "2000_10_29": 0x32,0x30,0x30,0x30,0x5F,0x31,0x30,0x5F,0x32,0x39, in that order.
REQ-013 Each byte SHALL be framed as start bit (0), 8 data bits LSB first, stop bit (1); each bit held exactly BIT_CYCLES clocks.
REQ-014 Bytes SHALL be sent back-to-back: next start bit immediately follows previous stop bit, no idle gap.
REQ-015 Controller FSM states: IDLE (tx=1, index=0), SEND (byte in progress), NEXT (advance index; go to SEND if index<9, else IDLE).
REQ-016 Press pulses arriving while not IDLE SHALL be ignored (no queuing, no restart).
REQ-017 Message start latency: first start bit SHALL appear on tx within 2 clocks after the press pulse.
REQ-018 After the 10th stop bit completes, tx SHALL stay high and FSM SHALL return to IDLE; a new press then resends the full message.
REQ-019 Bit counter SHALL be wide enough for BIT_CYCLES-1 (9 bits at defaults); debounce counter wide enough for DEBOUNCE_CYCLES-1 (20 bits).

Reset
REQ-020 While rst_n=1: tx=1, FSM=IDLE, byte index=0, bit and baud counters=0, debounce counter=0, synchronizer flops=1.
REQ-021 Reset asserted mid-message SHALL abort immediately (tx=1 asynchronously); after release nothing is sent until a new debounced press.
REQ-022 A key held low across reset release SHALL require a full DEBOUNCE_CYCLES of low after release before firing.

Structure
REQ-023 Shared package usb_key_birthday_pkg SHALL hold the FSM state enum, MSG_LEN=10 and the message byte array constant.
REQ-024 One sub-module uart_tx (inputs clk, rst_n, start, data[7:0]; outputs tx, busy, done) SHALL implement REQ-013; top holds synchronizer, debounce and message FSM.

Verification
REQ-025 Reset 14 ns, key low at 200 ns held 20.1 ms -> exactly one press pulse near 20.0002 ms; tx decodes "2000_10_29" at 115200 baud, total 10*10*434 clocks (~868 us).
REQ-026 key low 10 ms then high -> no press pulse, tx constantly 1.
REQ-027 Second valid press issued during transmission -> ignored, exactly 10 bytes sent; press after completion -> another 10 identical bytes.
REQ-028 Key bouncing (low/high toggles every 1 ms for 5 ms) then stable low 20 ms -> one press, one message.
REQ-029 Assert rst_n=1 during byte 4 -> tx immediately 1; after release, no further bytes without new press.
REQ-030 Bit timing check: each tx bit width measured = 434 clocks ±0; first start bit within 2 clocks of press pulse.
